// File: rtl/izigzag_pkg.sv
// izigzag_pkg: shared constants and types for the inverse-zigzag reorder buffer.
// ZZ2RASTER maps a zigzag scan index to its raster (row-major) position;
// RASTER2ZZ is the inverse mapping.
package izigzag_pkg;

   localparam int BLK = 64;

   typedef logic [5:0] coef_idx_t;

   localparam coef_idx_t ZZ2RASTER [BLK] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam coef_idx_t RASTER2ZZ [BLK] = '{
      6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
      6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
      6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
      6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
      6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
      6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
      6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
      6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
   };

endpackage

// File: rtl/izigzag_buffer_bank_ctrl.sv
// izz_bank_ctrl: one side (write or read) of the ping-pong buffer.
// Keeps the coefficient counter and bank pointer for that side, and reports
// which bank (one-hot) completes a block this cycle so the top can set or
// clear that bank's full flag.
module izz_bank_ctrl
   import izigzag_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step,
   input  logic       restart,
   output coef_idx_t  cnt,
   output logic       bank,
   output logic [1:0] done_mask
);

   logic wrap;

   // A block completes when the last index is consumed without a restart
   assign wrap      = step & ~restart & (cnt == coef_idx_t'(BLK - 1));
   assign done_mask = wrap ? (bank ? 2'b10 : 2'b01) : 2'b00;

   // Advance the counter on each handshake; a restart reloads it just past index 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         bank <= 1'b0;
      end else if (step) begin
         if (restart) begin
            cnt <= coef_idx_t'(1);
         end else begin
            cnt <= cnt + coef_idx_t'(1);
         end
         if (wrap) begin
            bank <= ~bank;
         end
      end
   end

endmodule

// File: rtl/izigzag_buffer.sv
// izigzag_buffer: accepts 8x8 coefficient blocks in zigzag order and emits
// them in raster order through two ping-pong banks (one fills, one drains).
// Optional macro IZZ_SOB_CHECK_EN adds in_sob / sync_err block alignment check.
module izigzag_buffer
   import izigzag_pkg::*;
#(
   parameter int DW    = 12,
   parameter int NBANK = 2
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_sob,
   output logic          out_eob
`ifdef IZZ_SOB_CHECK_EN
   ,
   input  logic          in_sob,
   output logic          sync_err
`endif
);

   if (NBANK != 2) begin : g_bad_nbank
      $error("izigzag_buffer: NBANK must be 2");
   end

   logic          active;
   logic [1:0]    full;
   coef_idx_t     wr_cnt;
   coef_idx_t     rd_cnt;
   logic          wr_bank;
   logic          rd_bank;
   logic [1:0]    wr_done;
   logic [1:0]    rd_done;
   logic          wr_fire;
   logic          rd_fire;
   logic          wr_restart;
   coef_idx_t     wr_addr;
   logic [DW-1:0] mem [NBANK][BLK];

   assign in_ready  = active & ~full[wr_bank];
   assign wr_fire   = in_valid & in_ready;
   assign out_valid = full[rd_bank];
   assign rd_fire   = out_valid & out_ready;
   assign out_data  = out_valid ? mem[rd_bank][rd_cnt] : '0;
   assign out_sob   = out_valid & (rd_cnt == coef_idx_t'(0));
   assign out_eob   = out_valid & (rd_cnt == coef_idx_t'(BLK - 1));

`ifdef IZZ_SOB_CHECK_EN
   // A start-of-block marker mid-block restarts the current bank at index 0
   assign wr_restart = wr_fire & in_sob & (wr_cnt != coef_idx_t'(0));

   // Flag any disagreement between the marker and the write count for one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_err <= 1'b0;
      end else begin
         sync_err <= wr_fire & (in_sob ? (wr_cnt != coef_idx_t'(0))
                                       : (wr_cnt == coef_idx_t'(0)));
      end
   end
`else
   assign wr_restart = 1'b0;
`endif

   assign wr_addr = wr_restart ? ZZ2RASTER[0] : ZZ2RASTER[wr_cnt];

   izz_bank_ctrl u_wr_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (wr_fire),
      .restart   (wr_restart),
      .cnt       (wr_cnt),
      .bank      (wr_bank),
      .done_mask (wr_done)
   );

   izz_bank_ctrl u_rd_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (rd_fire),
      .restart   (1'b0),
      .cnt       (rd_cnt),
      .bank      (rd_bank),
      .done_mask (rd_done)
   );

   // Hold off the writer until the first clock after reset has been released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
      end else begin
         active <= 1'b1;
      end
   end

   // Writer sets a bank's flag on completion, reader clears on drain; both may apply at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         full <= (full | wr_done) & ~rd_done;
      end
   end

   // Coefficient storage, written at the raster position of the incoming zigzag index
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_bank][wr_addr] <= in_data;
      end
   end

endmodule

// File: tb/tb_izigzag_buffer.sv
// tb_izigzag_buffer: directed and randomised checks of the inverse-zigzag buffer.
// Honours IZZ_SOB_CHECK_EN to exercise the in_sob / sync_err path.
module tb_izigzag_buffer;
   import izigzag_pkg::*;

   localparam int DW = 12;

   typedef struct packed {
      logic          acc_in;
      logic          acc_out;
      logic          ov;
      logic          ir;
      logic          sob;
      logic          eob;
      logic          serr;
      logic [5:0]    pos;
      logic [DW-1:0] data;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_sob;
   logic          out_eob;
`ifdef IZZ_SOB_CHECK_EN
   logic          in_sob = 1'b0;
   logic          sync_err;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model_blk [64];
   int            model_cnt = 0;
   logic [DW-1:0] exp_q [$];
   logic [5:0]    out_pos = '0;

   always #5 clk = ~clk;

   izigzag_buffer #(.DW(DW), .NBANK(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sob   (out_sob),
      .out_eob   (out_eob)
`ifdef IZZ_SOB_CHECK_EN
      ,
      .in_sob    (in_sob),
      .sync_err  (sync_err)
`endif
   );

   // Reference model: collect a block by zigzag index, release it in raster order
   task automatic model_push(input logic [DW-1:0] d, input logic s);
      if (s) model_cnt = 0;
      model_blk[model_cnt] = d;
      model_cnt++;
      if (model_cnt == 64) begin
         for (int r = 0; r < 64; r++) exp_q.push_back(model_blk[RASTER2ZZ[r]]);
         model_cnt = 0;
      end
   endtask

   // Drive one cycle from a negedge, observe outputs, advance to the next negedge
   task automatic tick(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic isob, output obs_t o);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
`ifdef IZZ_SOB_CHECK_EN
      in_sob = isob;
`endif
      #1;
`ifdef IZZ_SOB_CHECK_EN
      o.serr = sync_err;
`else
      o.serr = 1'b0;
`endif
      o.ir      = in_ready;
      o.ov      = out_valid;
      o.data    = out_data;
      o.sob     = out_sob;
      o.eob     = out_eob;
      o.pos     = out_pos;
      o.acc_in  = iv & in_ready;
      o.acc_out = out_valid & ordy;
      if (o.acc_in) model_push(id, isob);
      if (o.acc_out) out_pos = out_pos + 6'd1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL rst_in_ready got=%b req=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got=%b req=0", out_valid); end
      checks++; if (out_sob !== 1'b0)   begin errors++; $display("[TB] FAIL rst_out_sob got=%b req=0", out_sob); end
      checks++; if (out_eob !== 1'b0)   begin errors++; $display("[TB] FAIL rst_out_eob got=%b req=0", out_eob); end
      checks++; if (out_data !== '0)    begin errors++; $display("[TB] FAIL rst_out_data got=%h req=0", out_data); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL post_rst_in_ready got=%b req=1", in_ready); end
   endtask

   task automatic test_single_block();
      obs_t o;
      int k = 0, got = 0, cyc = 0, last_in = -1, first_ov = -1;
      logic [DW-1:0] exp_d;
      logic [DW-1:0] seen [64];
      int hr [5] = '{1, 2, 8, 16, 63};
      int hv [5] = '{1, 5, 2, 3, 63};
      while ((k < 64 || got < 64) && cyc < 400) begin
         tick(k < 64, DW'(k), 1'b1, 1'b0, o);
         if (o.ov && first_ov < 0) first_ov = cyc;
         if (o.acc_in) begin k++; if (k == 64) last_in = cyc; end
         if (o.acc_out) begin
            seen[o.pos] = o.data;
            got++;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (o.data !== exp_d) begin errors++; $display("[TB] FAIL single_data pos=%0d got=%h req=%h", o.pos, o.data, exp_d); end
            checks++; if (o.sob !== (o.pos == 0))  begin errors++; $display("[TB] FAIL single_sob pos=%0d got=%b", o.pos, o.sob); end
            checks++; if (o.eob !== (o.pos == 63)) begin errors++; $display("[TB] FAIL single_eob pos=%0d got=%b", o.pos, o.eob); end
         end
         cyc++;
      end
      checks++; if (got != 64) begin errors++; $display("[TB] FAIL single_count got=%0d req=64", got); end
      checks++; if (first_ov != last_in + 1) begin errors++; $display("[TB] FAIL single_latency got=%0d req=%0d", first_ov, last_in + 1); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (seen[hr[i]] !== DW'(hv[i])) begin errors++; $display("[TB] FAIL single_raster%0d got=%h req=%0d", hr[i], seen[hr[i]], hv[i]); end
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      int sent = 0, got = 0, cyc = 0, drops = 0, bubbles = 0, first_ov = -1, last_out = -1;
      logic [DW-1:0] exp_d;
      while ((sent < 256 || got < 256) && cyc < 1000) begin
         tick(sent < 256, DW'(sent) ^ 12'h9C3, 1'b1, 1'b0, o);
         if (sent < 256 && !o.ir) drops++;
         if (o.ov && first_ov < 0) first_ov = cyc;
         if (first_ov >= 0 && !o.ov && got < 256) bubbles++;
         if (o.acc_in) sent++;
         if (o.acc_out) begin
            got++;
            last_out = cyc;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (o.data !== exp_d) begin errors++; $display("[TB] FAIL b2b_data pos=%0d got=%h req=%h", o.pos, o.data, exp_d); end
            checks++; if (o.sob !== (o.pos == 0))  begin errors++; $display("[TB] FAIL b2b_sob pos=%0d got=%b", o.pos, o.sob); end
            checks++; if (o.eob !== (o.pos == 63)) begin errors++; $display("[TB] FAIL b2b_eob pos=%0d got=%b", o.pos, o.eob); end
         end
         cyc++;
      end
      checks++; if (got != 256)    begin errors++; $display("[TB] FAIL b2b_count got=%0d req=256", got); end
      checks++; if (drops != 0)    begin errors++; $display("[TB] FAIL b2b_in_ready_drops got=%0d req=0", drops); end
      checks++; if (bubbles != 0)  begin errors++; $display("[TB] FAIL b2b_bubbles got=%0d req=0", bubbles); end
      checks++; if (first_ov != 64) begin errors++; $display("[TB] FAIL b2b_first_out got=%0d req=64", first_ov); end
      checks++; if (last_out != 319) begin errors++; $display("[TB] FAIL b2b_last_out got=%0d req=319", last_out); end
   endtask

   task automatic test_backpressure();
      obs_t o;
      int sent = 0, got = 0, cyc = 0, drain_cyc = -1, rise_cyc = -1;
      logic [DW-1:0] exp_d;
      for (int c = 0; c < 140; c++) begin
         tick(1'b1, in_ready ? (12'h800 | DW'(sent)) : 12'hBAD, 1'b0, 1'b0, o);
         if (o.acc_in) sent++;
      end
      checks++; if (sent != 128)   begin errors++; $display("[TB] FAIL bp_accepted got=%0d req=128", sent); end
      checks++; if (o.ir !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low got=%b req=0", o.ir); end
      while ((sent < 192 || got < 192) && cyc < 600) begin
         tick(1'b1, in_ready ? (12'h800 | DW'(sent)) : 12'hBAD, 1'b1, 1'b0, o);
         if (o.ir && rise_cyc < 0) rise_cyc = cyc;
         if (o.acc_in) sent++;
         if (o.acc_out) begin
            got++;
            if (got == 64) drain_cyc = cyc;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (o.data !== exp_d) begin errors++; $display("[TB] FAIL bp_data pos=%0d got=%h req=%h", o.pos, o.data, exp_d); end
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got != 192) begin errors++; $display("[TB] FAIL bp_count got=%0d req=192", got); end
      checks++; if (rise_cyc != drain_cyc + 1) begin errors++; $display("[TB] FAIL bp_ready_rise got=%0d req=%0d", rise_cyc, drain_cyc + 1); end
   endtask

   task automatic test_random();
      obs_t o;
      int sent = 0, got = 0, cyc = 0;
      logic iv, ordy, prev_stall = 1'b0;
      logic [DW-1:0] d, exp_d, prev_data = '0;
      while ((sent < 1280 || got < 1280) && cyc < 15000) begin
         iv   = (sent < 1280) && ($urandom_range(0, 1) == 1);
         ordy = ($urandom_range(0, 1) == 1);
         d    = DW'($urandom);
         tick(iv, d, ordy, 1'b0, o);
         if (prev_stall) begin
            checks++;
            if (o.ov !== 1'b1 || o.data !== prev_data) begin errors++; $display("[TB] FAIL rnd_hold got=%b/%h req=1/%h", o.ov, o.data, prev_data); end
         end
         prev_stall = o.ov & ~ordy;
         prev_data  = o.data;
         if (o.acc_in) sent++;
         if (o.acc_out) begin
            got++;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (o.data !== exp_d) begin errors++; $display("[TB] FAIL rnd_data n=%0d got=%h req=%h", got, o.data, exp_d); end
            checks++; if (o.sob !== (o.pos == 0))  begin errors++; $display("[TB] FAIL rnd_sob pos=%0d got=%b", o.pos, o.sob); end
            checks++; if (o.eob !== (o.pos == 63)) begin errors++; $display("[TB] FAIL rnd_eob pos=%0d got=%b", o.pos, o.eob); end
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got != 1280) begin errors++; $display("[TB] FAIL rnd_count got=%0d req=1280", got); end
   endtask

   task automatic test_reset_midblock();
      obs_t o;
      int sent = 0, got = 0, cyc = 0, last_in = -1, first_ov = -1;
      logic [DW-1:0] exp_d;
      while (sent < 94 && cyc < 200) begin
         tick(1'b1, 12'h300 + DW'(sent), 1'b0, 1'b0, o);
         if (o.acc_in) sent++;
         cyc++;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid got=%b req=1", out_valid); end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL mid_in_ready got=%b req=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid got=%b req=0", out_valid); end
      checks++; if (out_sob !== 1'b0)   begin errors++; $display("[TB] FAIL mid_out_sob got=%b req=0", out_sob); end
      checks++; if (out_data !== '0)    begin errors++; $display("[TB] FAIL mid_out_data got=%h req=0", out_data); end
      exp_q.delete();
      model_cnt = 0;
      out_pos   = '0;
      @(negedge clk);
      rst_n = 1'b1;
      sent = 0;
      cyc  = 0;
      while ((sent < 64 || got < 64) && cyc < 400) begin
         tick(sent < 64, 12'h400 + DW'(sent * 3), 1'b1, 1'b0, o);
         if (o.ov && first_ov < 0) first_ov = cyc;
         if (o.acc_in) begin sent++; if (sent == 64) last_in = cyc; end
         if (o.acc_out) begin
            got++;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (o.data !== exp_d) begin errors++; $display("[TB] FAIL mid_data pos=%0d got=%h req=%h", o.pos, o.data, exp_d); end
         end
         cyc++;
      end
      checks++; if (got != 64) begin errors++; $display("[TB] FAIL mid_count got=%0d req=64", got); end
      checks++; if (first_ov != last_in + 1) begin errors++; $display("[TB] FAIL mid_latency got=%0d req=%0d", first_ov, last_in + 1); end
   endtask

`ifdef IZZ_SOB_CHECK_EN
   task automatic test_sob_check();
      obs_t o;
      int sent = 0, got = 0, cyc = 0, serr_cnt = 0, serr_at = -1, resync_cyc = -1;
      logic s;
      logic [DW-1:0] d, exp_d;
      while ((sent < 84 || got < 64) && cyc < 500) begin
         s = (sent == 0) || (sent == 20);
         d = (sent < 20) ? (12'h100 + DW'(sent)) : (12'h200 + DW'(sent - 20));
         tick(sent < 84, d, 1'b1, s, o);
         if (o.serr) begin serr_cnt++; serr_at = cyc; end
         if (o.acc_in) begin
            if (sent == 20) resync_cyc = cyc;
            sent++;
         end
         if (o.acc_out) begin
            got++;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (o.data !== exp_d) begin errors++; $display("[TB] FAIL sob_data pos=%0d got=%h req=%h", o.pos, o.data, exp_d); end
         end
         cyc++;
      end
      for (int c = 0; c < 4; c++) begin
         tick(1'b0, '0, 1'b1, 1'b0, o);
         if (o.serr) serr_cnt++;
         checks++; if (o.ov !== 1'b0) begin errors++; $display("[TB] FAIL sob_extra_out got=%b req=0", o.ov); end
      end
      checks++; if (got != 64)      begin errors++; $display("[TB] FAIL sob_count got=%0d req=64", got); end
      checks++; if (serr_cnt != 1)  begin errors++; $display("[TB] FAIL sob_err_count got=%0d req=1", serr_cnt); end
      checks++; if (serr_at != resync_cyc + 1) begin errors++; $display("[TB] FAIL sob_err_cycle got=%0d req=%0d", serr_at, resync_cyc + 1); end
   endtask
`endif

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_single_block();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midblock();
`ifdef IZZ_SOB_CHECK_EN
      test_sob_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
